interrupt_sequencer: RTL and testbench

Controller that turns an external interrupt request into a safe, multi-cycle pipeline sequence for the 5-stage RISC core. It waits for a safe point, freezes fetch and bubbles decode while older instructions drain, and pushes return PC (high, low) and CCR through a valid/ready stack-write port. It then redirects fetch to the interrupt vector. Sits beside the fetch/decode stages and drives their stall, flush and PC-load controls.

---
 rtl/isr_pkg.sv | 21 ++
 rtl/irq_edge_latch.sv | 39 +++
 rtl/interrupt_sequencer.sv | 154 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isr_pkg.sv
// Shared definitions for the interrupt entry sequencer.
//   isr_state_e      : sequencer state encoding (3 bits)
//   STACK_WORDS      : words pushed per interrupt entry (PC high, PC low, CCR)
//   DRAIN_CNT_W      : width of the drain-bubble counter (DRAIN_CYCLES 1..7)
//   VEC_ADDR_DEFAULT : default interrupt vector address
package isr_pkg;

  localparam int unsigned STACK_WORDS      = 3;
  localparam int unsigned DRAIN_CNT_W      = 3;
  localparam logic [31:0] VEC_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    PUSH_PCH = 3'd2,
    PUSH_PCL = 3'd3,
    PUSH_CCR = 3'd4,
    VECTOR   = 3'd5
  } isr_state_e;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector on the external interrupt line plus a one-deep
// pending flop. A new edge wins over a same-cycle clear, so an edge that
// lands in the vector cycle is not lost.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_req      : raw interrupt level
//   i_clr      : clear pending (sequencer vector cycle)
//   o_pending  : interrupt awaiting service
module irq_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_clr,
  output logic o_pending
);

  logic r_req_d;
  logic r_pending;
  logic w_rise;

  assign w_rise    = i_req & ~r_req_d;
  assign o_pending = r_pending;

  // Edge register and pending flop; set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_d   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_req_d <= i_req;
      if (w_rise) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer for the 5-stage core. Waits for a safe point,
// freezes fetch and bubbles decode while older instructions drain, pushes
// return PC (high, low) and CCR through a valid/ready stack port, then
// redirects fetch to the interrupt vector.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   int_req               : external interrupt level (rising edge requests)
//   rti_done              : RTI retired, clears the nesting mask
//   safe_point            : no load-use stall / ldm 2nd word / branch flush pending
//   resume_pc, ccr        : state captured at entry
//   fetch_stall           : hold PC and IF/ID
//   ifid_flush            : zero IF/ID
//   idex_bubble           : zero control word into ID/EX
//   push_valid/data/ready : stack-write handshake
//   pc_load, pc_load_addr : PC redirect strobe and target
//   int_ack               : one-cycle acknowledge
//   busy                  : sequence in progress
module interrupt_sequencer
  import isr_pkg::*;
#(
  parameter int unsigned      PC_W         = 32,
  parameter int unsigned      DATA_W       = 16,
  parameter int unsigned      CCR_W        = 3,
  parameter logic [PC_W-1:0]  VEC_ADDR     = PC_W'(VEC_ADDR_DEFAULT),
  parameter int unsigned      DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              rti_done,
  input  logic              safe_point,
  input  logic [PC_W-1:0]   resume_pc,
  input  logic [CCR_W-1:0]  ccr,
  output logic              fetch_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              push_valid,
  output logic [DATA_W-1:0] push_data,
  input  logic              push_ready,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_addr,
  output logic              int_ack,
  output logic              busy
);

  isr_state_e             r_state;
  logic                   r_mask;
  logic [DRAIN_CNT_W-1:0] r_cnt;
  logic [PC_W-1:0]        r_saved_pc;
  logic [CCR_W-1:0]       r_saved_ccr;

  logic w_pending;
  logic w_clr;
  logic w_start;

  assign w_clr   = (r_state == VECTOR);
  assign w_start = w_pending & ~r_mask & safe_point;

  irq_edge_latch u_edge (
    .clk       (clk),
    .rst       (rst),
    .i_req     (int_req),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  // Sequencer state, drain counter, mask and captured return context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mask      <= 1'b0;
      r_cnt       <= '0;
      r_saved_pc  <= '0;
      r_saved_ccr <= '0;
    end else begin
      // Mask blocks nesting until the handler returns.
      if (r_state == VECTOR) begin
        r_mask <= 1'b1;
      end else if (rti_done) begin
        r_mask <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_saved_pc  <= resume_pc;
            r_saved_ccr <= ccr;
            r_cnt       <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          // Counter preloaded with N-1 so DRAIN lasts exactly N cycles.
          if (r_cnt == '0) begin
            r_state <= PUSH_PCH;
          end else begin
            r_cnt <= r_cnt - DRAIN_CNT_W'(1);
          end
        end
        PUSH_PCH: if (push_ready) r_state <= PUSH_PCL;
        PUSH_PCL: if (push_ready) r_state <= PUSH_CCR;
        PUSH_CCR: if (push_ready) r_state <= VECTOR;
        VECTOR:   r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // Pipeline controls and stack data are a pure decode of the state.
  always_comb begin
    fetch_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    push_valid  = 1'b0;
    push_data   = '0;
    pc_load     = 1'b0;
    int_ack     = 1'b0;
    case (r_state)
      DRAIN: begin
        fetch_stall = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      PUSH_PCH: begin
        fetch_stall = 1'b1;
        idex_bubble = 1'b1;
        push_valid  = 1'b1;
        push_data   = r_saved_pc[PC_W-1 -: DATA_W];
      end
      PUSH_PCL: begin
        fetch_stall = 1'b1;
        idex_bubble = 1'b1;
        push_valid  = 1'b1;
        push_data   = r_saved_pc[DATA_W-1:0];
      end
      PUSH_CCR: begin
        fetch_stall = 1'b1;
        idex_bubble = 1'b1;
        push_valid  = 1'b1;
        push_data   = DATA_W'(r_saved_ccr);
      end
      VECTOR: begin
        ifid_flush = 1'b1;
        pc_load    = 1'b1;
        int_ack    = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_load_addr = VEC_ADDR;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: stimulus posts cycle-stamped expectations, the monitor
// matches them against what the sequencer presents on each falling edge.
module tb_interrupt_sequencer;
  import isr_pkg::*;

  localparam logic [31:0] EXP_VEC = 32'h0000_0000;
  // flags = {busy, fetch_stall, ifid_flush, idex_bubble, push_valid, pc_load, int_ack}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_DRAIN = 7'b1111000;
  localparam logic [6:0] O_PUSH  = 7'b1101100;
  localparam logic [6:0] O_VEC   = 7'b1010011;

  typedef enum logic [1:0] {K_OUTS, K_PUSH, K_VEC} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [6:0]  outs;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_req = 1'b0;
  logic        rti_done = 1'b0;
  logic        safe_point = 1'b1;
  logic [31:0] resume_pc = '0;
  logic [2:0]  ccr = '0;
  logic        push_ready = 1'b1;
  logic        fetch_stall, ifid_flush, idex_bubble, push_valid, pc_load, int_ack, busy;
  logic [15:0] push_data;
  logic [31:0] pc_load_addr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  exp_t sb[$];

  interrupt_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .int_req      (int_req),
    .rti_done     (rti_done),
    .safe_point   (safe_point),
    .resume_pc    (resume_pc),
    .ccr          (ccr),
    .fetch_stall  (fetch_stall),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .int_ack      (int_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  logic [6:0]  m_outs;
  logic        m_hs, m_saw_push, m_saw_vec, m_hold_v;
  logic [15:0] m_hold_d;
  exp_t        m_e;

  initial begin
    m_hold_v = 1'b0;
    m_hold_d = '0;
  end

  always @(negedge clk) begin
    m_outs     = {busy, fetch_stall, ifid_flush, idex_bubble, push_valid, pc_load, int_ack};
    m_hs       = !rst && push_valid && push_ready;
    m_saw_push = 1'b0;
    m_saw_vec  = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      m_e = sb[i];
      if (m_e.cyc == cyc) begin
        checks++;
        case (m_e.kind)
          K_OUTS: if (m_outs !== m_e.outs || push_data !== m_e.data || pc_load_addr !== EXP_VEC) begin
            errors++;
            $display("FAIL outs cyc=%0d: got flags=%b data=%h addr=%h, want flags=%b data=%h addr=%h",
                     cyc, m_outs, push_data, pc_load_addr, m_e.outs, m_e.data, EXP_VEC);
          end
          K_PUSH: begin
            m_saw_push = 1'b1;
            if (!m_hs || push_data !== m_e.data) begin
              errors++;
              $display("FAIL push cyc=%0d: got accepted=%b data=%h, want accepted=1 data=%h",
                       cyc, m_hs, push_data, m_e.data);
            end
          end
          default: begin
            m_saw_vec = 1'b1;
            if (!pc_load || !int_ack || pc_load_addr !== EXP_VEC) begin
              errors++;
              $display("FAIL vector cyc=%0d: got pc_load=%b int_ack=%b addr=%h, want 1 1 %h",
                       cyc, pc_load, int_ack, pc_load_addr, EXP_VEC);
            end
          end
        endcase
        sb.delete(i);
      end else if (m_e.cyc < cyc || done) begin
        checks++;
        errors++;
        $display("FAIL missed cyc=%0d: expectation for cycle %0d kind=%0d never checked", cyc, m_e.cyc, m_e.kind);
        sb.delete(i);
      end
    end
    if (m_hs && !m_saw_push) begin
      checks++;
      errors++;
      $display("FAIL extra_push cyc=%0d: got accepted word %h, want no push", cyc, push_data);
    end
    if (!rst && (pc_load || int_ack) && !m_saw_vec) begin
      checks++;
      errors++;
      $display("FAIL extra_ack cyc=%0d: got pc_load=%b int_ack=%b, want 0 0", cyc, pc_load, int_ack);
    end
    // A stalled push must keep valid and data unchanged.
    if (!rst && m_hold_v) begin
      checks++;
      if (!push_valid || push_data !== m_hold_d) begin
        errors++;
        $display("FAIL hold cyc=%0d: got valid=%b data=%h, want valid=1 data=%h", cyc, push_valid, push_data, m_hold_d);
      end
    end
    m_hold_v = !rst && push_valid && !push_ready;
    m_hold_d = push_data;
    if (done) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic add(input int c, input kind_e k, input logic [6:0] o, input logic [15:0] d);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.outs = o;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic add_idle(input int from, input int n);
    for (int i = 0; i < n; i++) add(from + i, K_OUTS, O_IDLE, 16'h0);
  endtask

  // Expected entry sequence when the rising edge is sampled at the end of
  // cycle k (or the equivalent IDLE decision happens at the end of k+1).
  // st = wait cycles on the PCL word; full=0 stops after the PCH word.
  task automatic exp_seq(input int k, input logic [31:0] pc, input logic [2:0] cc,
                         input int st, input bit full);
    logic [15:0] w [STACK_WORDS];
    w[0] = pc[31:16];
    w[1] = pc[15:0];
    w[2] = {13'b0, cc};
    add(k + 1, K_OUTS, O_IDLE, 16'h0);
    for (int d = 2; d <= 4; d++) add(k + d, K_OUTS, O_DRAIN, 16'h0);
    add(k + 5, K_OUTS, O_PUSH, w[0]);
    add(k + 5, K_PUSH, O_IDLE, w[0]);
    if (!full) return;
    for (int t = 0; t <= st; t++) add(k + 6 + t, K_OUTS, O_PUSH, w[1]);
    add(k + 6 + st, K_PUSH, O_IDLE, w[1]);
    add(k + 7 + st, K_OUTS, O_PUSH, w[2]);
    add(k + 7 + st, K_PUSH, O_IDLE, w[2]);
    add(k + 8 + st, K_OUTS, O_VEC, 16'h0);
    add(k + 8 + st, K_VEC, O_IDLE, 16'h0);
    add(k + 9 + st, K_OUTS, O_IDLE, 16'h0);
  endtask

  task automatic pulse_rti();
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    tick();
    add(cyc, K_OUTS, O_IDLE, 16'h0);   // in reset
    tick();
    rst = 1'b0;

    // Basic entry, no backpressure.
    resume_pc = 32'h0001_2345;
    ccr       = 3'b101;
    k = cyc;
    int_req = 1'b1;
    exp_seq(k, 32'h0001_2345, 3'b101, 0, 1'b1);
    tick();
    int_req = 1'b0;
    wait_until(k + 11);

    // Backpressure: four stalled cycles on the PCL word.
    pulse_rti();
    tick();
    k = cyc;
    int_req = 1'b1;
    exp_seq(k, 32'h0001_2345, 3'b101, 4, 1'b1);
    tick();
    int_req = 1'b0;
    wait_until(k + 6);
    push_ready = 1'b0;
    wait_until(k + 10);
    push_ready = 1'b1;
    wait_until(k + 15);

    // Safe-point wait; capture must use resume_pc of the decision cycle.
    pulse_rti();
    tick();
    safe_point = 1'b0;
    ccr        = 3'b010;
    k = cyc;
    int_req = 1'b1;
    add_idle(k + 1, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      int_req   = 1'b0;
      resume_pc = 32'hA000_0000 + 32'(i);
    end
    safe_point = 1'b1;
    resume_pc  = 32'hDEAD_BEEF;
    exp_seq(cyc - 1, 32'hDEAD_BEEF, 3'b010, 0, 1'b1);
    k = cyc;
    tick();
    resume_pc  = 32'h1111_1111;
    ccr        = 3'b000;
    safe_point = 1'b0;
    wait_until(k + 10);
    safe_point = 1'b1;

    // Masked edge waits for rti_done.
    resume_pc = 32'h8000_7FFF;
    ccr       = 3'b111;
    k = cyc;
    int_req = 1'b1;
    add_idle(k + 1, 5);
    tick();
    int_req = 1'b0;
    wait_until(k + 5);
    k = cyc;
    exp_seq(k, 32'h8000_7FFF, 3'b111, 0, 1'b1);
    pulse_rti();
    wait_until(k + 11);

    // Coincident rti_done + edge, then an absorbed edge during DRAIN.
    resume_pc = 32'h0BAD_F00D;
    ccr       = 3'b011;
    k = cyc;
    int_req  = 1'b1;
    rti_done = 1'b1;
    exp_seq(k, 32'h0BAD_F00D, 3'b011, 0, 1'b1);
    tick();
    int_req  = 1'b0;
    rti_done = 1'b0;
    tick();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    wait_until(k + 11);
    k = cyc;
    add_idle(k + 1, 5);
    pulse_rti();
    wait_until(k + 7);

    // Asynchronous reset in the middle of PUSH_PCL.
    resume_pc = 32'h1234_5678;
    ccr       = 3'b001;
    k = cyc;
    int_req = 1'b1;
    exp_seq(k, 32'h1234_5678, 3'b001, 0, 1'b0);
    tick();
    int_req = 1'b0;
    wait_until(k + 6);
    #2;
    rst = 1'b1;
    add(k + 6, K_OUTS, O_IDLE, 16'h0);
    tick();
    add(cyc, K_OUTS, O_IDLE, 16'h0);
    rst = 1'b0;
    add_idle(cyc + 1, 4);
    wait_until(cyc + 5);
    resume_pc = 32'hCAFE_0042;
    ccr       = 3'b110;
    k = cyc;
    int_req = 1'b1;
    exp_seq(k, 32'hCAFE_0042, 3'b110, 0, 1'b1);
    tick();
    int_req = 1'b0;
    wait_until(k + 11);

    // Reset while masked: mask must clear so a new edge is serviced.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    resume_pc = 32'h0000_FFFE;
    ccr       = 3'b100;
    k = cyc;
    int_req = 1'b1;
    exp_seq(k, 32'h0000_FFFE, 3'b100, 0, 1'b1);
    tick();
    int_req = 1'b0;
    wait_until(k + 12);

    done = 1'b1;
  end

endmodule
